// File: rtl/icb_regfile_param.sv
// ICB slave register file: N_RW byte-maskable control registers followed by N_RO
// status registers, with a single registered response slot and per-register write strobes.
module icb_regfile_param #(
  parameter int unsigned N_RW    = 32,
  parameter int unsigned N_RO    = 12,
  parameter int unsigned IDX_W   = 7,
  parameter logic [31:0] RST_VAL = 32'h0
) (
  input  logic                                     clk,
  input  logic                                     rst_n,
  input  logic                                     i_icb_cmd_valid,
  output logic                                     i_icb_cmd_ready,
  input  logic [31:0]                              i_icb_cmd_addr,
  input  logic                                     i_icb_cmd_read,
  input  logic [31:0]                              i_icb_cmd_wdata,
  input  logic [3:0]                               i_icb_cmd_wmask,
  output logic                                     i_icb_rsp_valid,
  input  logic                                     i_icb_rsp_ready,
  output logic [31:0]                              i_icb_rsp_rdata,
  output logic                                     i_icb_rsp_err,
  input  logic [((N_RO > 0) ? 32*N_RO : 32)-1:0]   ro_data_i,
  output logic [32*N_RW-1:0]                       rw_data_o,
  output logic [N_RW-1:0]                          wr_stb_o
);

  localparam int unsigned RO_N  = (N_RO > 0) ? N_RO : 1;
  localparam int unsigned RW_AW = (N_RW > 1) ? $clog2(N_RW) : 1;
  localparam int unsigned RO_AW = (RO_N > 1) ? $clog2(RO_N) : 1;

  logic [IDX_W-1:0] idx;
  logic [RW_AW-1:0] rw_idx;
  logic [RO_AW-1:0] ro_idx;
  logic             is_rw, is_ro, misaligned, acc_err, accept, wr_en;
  logic [31:0]      rd_mux;
  logic [31:0]      rw_arr [N_RW];
  logic [31:0]      ro_arr [RO_N];
  logic [N_RW-1:0]  wr_dec;
  logic             unused_addr_hi;

  logic             rsp_valid_q, rsp_valid_d;
  logic [31:0]      rsp_rdata_q, rsp_rdata_d;
  logic             rsp_err_q, rsp_err_d;
  logic [N_RW-1:0]  wr_stb_q;

  assign unused_addr_hi = ^i_icb_cmd_addr[31:IDX_W+2];

  assign i_icb_cmd_ready = ~rsp_valid_q | i_icb_rsp_ready;
  assign accept          = i_icb_cmd_valid & i_icb_cmd_ready;

  assign idx        = i_icb_cmd_addr[IDX_W+1:2];
  assign rw_idx     = RW_AW'(idx);
  assign ro_idx     = RO_AW'(32'(idx) - N_RW);
  assign misaligned = |i_icb_cmd_addr[1:0];
  assign is_rw      = 32'(idx) < N_RW;
  assign is_ro      = (32'(idx) >= N_RW) && (32'(idx) < N_RW + N_RO);
  // RO targets are legal only for reads; everything else outside the RW window errors.
  assign acc_err    = misaligned | ~(is_rw | (is_ro & i_icb_cmd_read));
  assign wr_en      = accept & ~i_icb_cmd_read & ~acc_err;

  for (genvar j = 0; j < RO_N; j++) begin : g_ro
    assign ro_arr[j] = ro_data_i[32*j +: 32];
  end

  assign rd_mux = is_rw ? rw_arr[rw_idx] : ro_arr[ro_idx];

  for (genvar i = 0; i < N_RW; i++) begin : g_rw
    logic [31:0] reg_q, reg_d;

    always_comb begin
      reg_d = reg_q;
      if (wr_en && (rw_idx == RW_AW'(i))) begin
        for (int unsigned k = 0; k < 4; k++) begin
          if (i_icb_cmd_wmask[k]) reg_d[8*k +: 8] = i_icb_cmd_wdata[8*k +: 8];
        end
      end
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) reg_q <= RST_VAL;
      else        reg_q <= reg_d;
    end

    assign rw_arr[i]             = reg_q;
    assign rw_data_o[32*i +: 32] = reg_q;
  end

  always_comb begin
    wr_dec = '0;
    if (wr_en) wr_dec[rw_idx] = 1'b1;
  end

  // A new accept overrides a consumed response, keeping one transaction per cycle.
  always_comb begin
    rsp_valid_d = rsp_valid_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;
    if (accept) begin
      rsp_valid_d = 1'b1;
      rsp_err_d   = acc_err;
      rsp_rdata_d = (i_icb_cmd_read && !acc_err) ? rd_mux : '0;
    end else if (i_icb_rsp_ready) begin
      rsp_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
      wr_stb_q    <= '0;
    end else begin
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
      wr_stb_q    <= wr_dec;
    end
  end

  assign i_icb_rsp_valid = rsp_valid_q;
  assign i_icb_rsp_rdata = rsp_rdata_q;
  assign i_icb_rsp_err   = rsp_err_q;
  assign wr_stb_o        = wr_stb_q;

endmodule

// File: tb/tb_icb_regfile_param.sv
// Bench for icb_regfile_param: directed scenarios plus random traffic checked
// against an array-based model of the register map.
module tb_icb_regfile_param;

  localparam int unsigned N_RW  = 32;
  localparam int unsigned N_RO  = 12;
  localparam int unsigned IDX_W = 7;

  logic                 clk = 1'b0;
  logic                 rst_n;
  logic                 cmd_valid, cmd_ready, cmd_read;
  logic [31:0]          cmd_addr, cmd_wdata;
  logic [3:0]           cmd_wmask;
  logic                 rsp_valid, rsp_ready, rsp_err;
  logic [31:0]          rsp_rdata;
  logic [32*N_RO-1:0]   ro_data;
  logic [32*N_RW-1:0]   rw_data;
  logic [N_RW-1:0]      wr_stb;

  int unsigned checks = 0;
  int unsigned passes = 0;
  logic [31:0] rw_m [N_RW];

  icb_regfile_param #(.N_RW(N_RW), .N_RO(N_RO), .IDX_W(IDX_W), .RST_VAL(32'h0)) dut (
    .clk(clk), .rst_n(rst_n),
    .i_icb_cmd_valid(cmd_valid), .i_icb_cmd_ready(cmd_ready),
    .i_icb_cmd_addr(cmd_addr), .i_icb_cmd_read(cmd_read),
    .i_icb_cmd_wdata(cmd_wdata), .i_icb_cmd_wmask(cmd_wmask),
    .i_icb_rsp_valid(rsp_valid), .i_icb_rsp_ready(rsp_ready),
    .i_icb_rsp_rdata(rsp_rdata), .i_icb_rsp_err(rsp_err),
    .ro_data_i(ro_data), .rw_data_o(rw_data), .wr_stb_o(wr_stb)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  // Reference: decode by index arithmetic, apply byte masks to the model array.
  task automatic model(input bit rd, input logic [31:0] a, input logic [31:0] wd,
                       input logic [3:0] wm, output logic [31:0] e_rd,
                       output logic e_err, output logic [N_RW-1:0] e_stb);
    int unsigned ix;
    ix    = (a >> 2) % (1 << IDX_W);
    e_rd  = '0;
    e_err = 1'b0;
    e_stb = '0;
    if ((a % 4) != 0 || ix >= N_RW + N_RO || (!rd && ix >= N_RW)) e_err = 1'b1;
    else if (rd) e_rd = (ix < N_RW) ? rw_m[ix] : ro_data[32*(ix-N_RW) +: 32];
    else begin
      for (int b = 0; b < 4; b++) if (wm[b]) rw_m[ix][8*b +: 8] = wd[8*b +: 8];
      e_stb[ix] = 1'b1;
    end
  endtask

  task automatic txn(input bit rd, input logic [31:0] a, input logic [31:0] wd,
                     input logic [3:0] wm, output logic [31:0] o_rd,
                     output logic o_err, output logic [N_RW-1:0] o_stb);
    int unsigned n = 0;
    @(negedge clk);
    cmd_valid = 1'b1; cmd_read = rd; cmd_addr = a; cmd_wdata = wd; cmd_wmask = wm;
    while (!cmd_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (n >= 20) chk("accept_timeout", 64'(cmd_ready), 64'd1);
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    @(negedge clk);
    chk("rsp_valid_after_accept", 64'(rsp_valid), 64'd1);
    o_rd = rsp_rdata; o_err = rsp_err; o_stb = wr_stb;
  endtask

  task automatic access(input string tag, input bit rd, input logic [31:0] a,
                        input logic [31:0] wd, input logic [3:0] wm);
    logic [31:0] e_rd, o_rd;
    logic e_err, o_err;
    logic [N_RW-1:0] e_stb, o_stb;
    model(rd, a, wd, wm, e_rd, e_err, e_stb);
    txn(rd, a, wd, wm, o_rd, o_err, o_stb);
    chk({tag, "_rdata"}, 64'(o_rd), 64'(e_rd));
    chk({tag, "_err"}, 64'(o_err), 64'(e_err));
    chk({tag, "_stb"}, 64'(o_stb), 64'(e_stb));
  endtask

  task automatic check_rw_bus(input string tag);
    for (int i = 0; i < N_RW; i++) chk(tag, 64'(rw_data[32*i +: 32]), 64'(rw_m[i]));
  endtask

  initial begin
    logic [31:0] rd_v, a;
    logic err_v;
    logic [N_RW-1:0] stb_v;
    int unsigned ix;

    rst_n = 1'b0; cmd_valid = 1'b0; cmd_read = 1'b0; cmd_addr = '0;
    cmd_wdata = '0; cmd_wmask = '0; rsp_ready = 1'b1; ro_data = '0;
    for (int i = 0; i < N_RW; i++) rw_m[i] = 32'h0;
    repeat (3) @(negedge clk);
    chk("reset_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("reset_rsp_rdata", 64'(rsp_rdata), 64'd0);
    chk("reset_rsp_err", 64'(rsp_err), 64'd0);
    chk("reset_wr_stb", 64'(wr_stb), 64'd0);
    rst_n = 1'b1;

    for (int i = 0; i < N_RW; i++) access("reset_read", 1'b1, 32'(4*i), '0, '0);

    access("wr_deadbeef", 1'b0, 32'h4, 32'hDEADBEEF, 4'hF);
    @(negedge clk);
    chk("stb_single_pulse", 64'(wr_stb), 64'd0);
    chk("rw_bus_reg1", 64'(rw_data[63:32]), 64'hDEADBEEF);
    access("rd_deadbeef", 1'b1, 32'h4, '0, '0);

    access("wr_reg2_full", 1'b0, 32'h8, 32'h11223344, 4'hF);
    access("wr_reg2_mask", 1'b0, 32'h8, 32'hAABBCCDD, 4'b0101);
    txn(1'b1, 32'h8, '0, '0, rd_v, err_v, stb_v);
    chk("bytemask_literal", 64'(rd_v), 64'h11BB33DD);
    access("wr_zero_mask", 1'b0, 32'hC, 32'hFFFFFFFF, 4'h0);

    ro_data[32*3 +: 32] = 32'h00001234;
    access("ro_read", 1'b1, 32'(4*(N_RW+3)), '0, '0);
    access("ro_write_err", 1'b0, 32'(4*(N_RW+3)), 32'hCAFEF00D, 4'hF);
    access("ro_read_after_wr", 1'b1, 32'(4*(N_RW+3)), '0, '0);
    check_rw_bus("rw_bus_after_ro_wr");
    access("unmapped_read", 1'b1, 32'(4*(N_RW+N_RO)), '0, '0);
    access("unmapped_read_hi", 1'b1, 32'hBC, '0, '0);
    access("misaligned_wr", 1'b0, 32'h6, 32'h55555555, 4'hF);
    access("reg1_after_misaligned", 1'b1, 32'h4, '0, '0);
    access("addr_hi_ignored", 1'b1, 32'hF000_0004, '0, '0);

    // Back-pressure: hold response, queue a second command, release with it pending.
    @(negedge clk);
    rsp_ready = 1'b0;
    cmd_valid = 1'b1; cmd_read = 1'b1; cmd_addr = 32'h4;
    chk("bp_first_ready", 64'(cmd_ready), 64'd1);
    @(posedge clk);
    #1 cmd_addr = 32'h8;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      chk("bp_hold_valid", 64'(rsp_valid), 64'd1);
      chk("bp_hold_ready", 64'(cmd_ready), 64'd0);
      chk("bp_hold_rdata", 64'(rsp_rdata), 64'(rw_m[1]));
    end
    rsp_ready = 1'b1;
    #1 chk("bp_release_ready", 64'(cmd_ready), 64'd1);
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    @(negedge clk);
    chk("b2b_valid", 64'(rsp_valid), 64'd1);
    chk("b2b_rdata", 64'(rsp_rdata), 64'(rw_m[2]));
    @(negedge clk);
    chk("b2b_drain", 64'(rsp_valid), 64'd0);

    for (int it = 0; it < 250; it++) begin
      ix = ($urandom % 4 != 0) ? $urandom_range(0, N_RW + N_RO - 1)
                               : $urandom_range(0, (1 << IDX_W) - 1);
      a  = ($urandom << (IDX_W + 2)) | (ix << 2);
      if ($urandom % 8 == 0) a = a | 32'($urandom_range(1, 3));
      ro_data[32*$urandom_range(0, N_RO-1) +: 32] = $urandom;
      access("rand", 1'($urandom), a, $urandom, 4'($urandom));
      if (it % 25 == 0) check_rw_bus("rand_rw_bus");
    end
    check_rw_bus("rand_rw_bus_final");

    // Reset while a response is pending.
    @(negedge clk);
    rsp_ready = 1'b0;
    cmd_valid = 1'b1; cmd_read = 1'b1; cmd_addr = 32'h4;
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    @(negedge clk);
    chk("pre_reset_valid", 64'(rsp_valid), 64'd1);
    #2 rst_n = 1'b0;
    #1 chk("async_rst_valid", 64'(rsp_valid), 64'd0);
    chk("async_rst_reg1", 64'(rw_data[63:32]), 64'd0);
    for (int i = 0; i < N_RW; i++) rw_m[i] = 32'h0;
    @(negedge clk);
    rst_n = 1'b1; rsp_ready = 1'b1;
    for (int i = 0; i < N_RW; i++) access("post_reset_read", 1'b1, 32'(4*i), '0, '0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
